// File: rtl/instr_fetch_pkg.sv
// Shared widths, state encoding and instruction layout for the WF8 fetch unit.
package instr_fetch_pkg;

  localparam int unsigned INSTR_W    = 8;
  localparam int unsigned OPCODE_W   = 5;
  localparam int unsigned OPERAND_W  = 3;
  localparam int unsigned IF_STATE_W = 2;

  typedef enum logic [IF_STATE_W-1:0] {
    IF_RESET = 2'd0,
    IF_FETCH = 2'd1,
    IF_ISSUE = 2'd2,
    IF_HALT  = 2'd3
  } if_state_e;

  // Instruction byte: opcode in [7:3], operand in [2:0]
  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [OPERAND_W-1:0] operand;
  } instr_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus bundle: instruction memory port plus the issue/redirect
// port toward execute.
//   master (fetch unit): drives mem_req/mem_addr, instr_valid, opcode,
//                        operand, issue_pc, halted
//   slave  (memory + execute): drives mem_ready/mem_rdata, instr_ready,
//                        redirect_en/redirect_pc, halt
interface instr_fetch_if #(
  parameter int unsigned PC_W = 8
);
  import instr_fetch_pkg::*;

  logic                 mem_req;
  logic [PC_W-1:0]      mem_addr;
  logic                 mem_ready;
  logic [INSTR_W-1:0]   mem_rdata;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [OPCODE_W-1:0]  opcode;
  logic [OPERAND_W-1:0] operand;
  logic [PC_W-1:0]      issue_pc;

  logic                 redirect_en;
  logic [PC_W-1:0]      redirect_pc;
  logic                 halt;
  logic                 halted;

  modport master (
    output mem_req, mem_addr, instr_valid, opcode, operand, issue_pc, halted,
    input  mem_ready, mem_rdata, instr_ready, redirect_en, redirect_pc, halt
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, opcode, operand, issue_pc, halted,
    output mem_ready, mem_rdata, instr_ready, redirect_en, redirect_pc, halt
  );

endinterface

// File: rtl/instr_fetch.sv
// WF8 fetch/issue front end. Owns the PC, fetches one instruction byte per
// memory request, holds it as opcode/operand/issue_pc until execute accepts
// it, and applies execute's redirect/halt on the accepting edge.
// Ports:
//   clk   - core clock
//   rst_n - synchronous active-low reset
//   bus   - instr_fetch_if.master (memory port, issue port, redirect/halt)
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  if_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] issue_pc_q;
  instr_t          instr_q;
  logic            fetch_done;
  logic            issue_acc;

  // Handshake qualifiers; also gate the datapath updates
  assign fetch_done = (state_q == IF_FETCH) && bus.mem_ready;
  assign issue_acc  = (state_q == IF_ISSUE) && bus.instr_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IF_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IF_RESET: state_d = IF_FETCH;
      IF_FETCH: if (fetch_done) state_d = IF_ISSUE;
      IF_ISSUE: if (issue_acc)  state_d = bus.halt ? IF_HALT : IF_FETCH;
      IF_HALT:  state_d = IF_HALT;
    endcase
  end

  // PC and instruction register; pc already points past the issued
  // instruction, so acceptance only changes it on a redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      issue_pc_q <= '0;
      instr_q    <= '0;
    end else if (fetch_done) begin
      instr_q    <= instr_t'(bus.mem_rdata);
      issue_pc_q <= pc_q;
      pc_q       <= pc_q + PC_W'(1);
    end else if (issue_acc && bus.redirect_en) begin
      pc_q       <= bus.redirect_pc;
    end
  end

  // Outputs come from registers or are decoded from state only
  assign bus.mem_req     = (state_q == IF_FETCH);
  assign bus.mem_addr    = pc_q;
  assign bus.instr_valid = (state_q == IF_ISSUE);
  assign bus.halted      = (state_q == IF_HALT);
  assign bus.opcode      = instr_q.opcode;
  assign bus.operand     = instr_q.operand;
  assign bus.issue_pc    = issue_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed stimulus with literal expectations, plus a
// cycle-level reference of the visible fetch/issue behaviour checked on
// every falling edge.
module tb_instr_fetch;

  localparam int unsigned PC_W     = 8;
  localparam logic [7:0]  RESET_PC = 8'h00;

  // Visible status of the fetch unit as seen from outside
  localparam int EXP_QUIET = 0;  // in or just out of reset, nothing shown
  localparam int EXP_REQ   = 1;  // requesting an instruction
  localparam int EXP_SHOW  = 2;  // presenting an instruction
  localparam int EXP_PARK  = 3;  // halted

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] mem [256];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  int         m_st  = EXP_QUIET;
  logic [7:0] m_pc  = 8'h00;
  logic [7:0] m_ins = 8'h00;
  logic [7:0] m_ipc = 8'h00;

  int cnt;

  instr_fetch_if #(.PC_W(PC_W)) bus ();

  instr_fetch #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: junk on the data bus whenever it is not valid
  assign bus.mem_rdata = bus.mem_ready ? mem[bus.mem_addr] : 8'h5A;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what each edge does according to the handshake rules
  always @(posedge clk) begin
    if (!rst_n) begin
      m_st  = EXP_QUIET;
      m_pc  = RESET_PC;
      m_ins = 8'h00;
      m_ipc = 8'h00;
    end else if (m_st == EXP_QUIET) begin
      m_st = EXP_REQ;
    end else if (m_st == EXP_REQ && bus.mem_ready) begin
      m_ins = mem[m_pc];
      m_ipc = m_pc;
      m_pc  = m_pc + 8'd1;
      m_st  = EXP_SHOW;
    end else if (m_st == EXP_SHOW && bus.instr_ready) begin
      if (bus.redirect_en) m_pc = bus.redirect_pc;
      m_st = bus.halt ? EXP_PARK : EXP_REQ;
    end
  end

  // Per-cycle comparison against the reference
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_mem_req",     32'(bus.mem_req),     32'(m_st == EXP_REQ));
      check("cyc_instr_valid", 32'(bus.instr_valid), 32'(m_st == EXP_SHOW));
      check("cyc_halted",      32'(bus.halted),      32'(m_st == EXP_PARK));
      check("cyc_opcode",      32'(bus.opcode),      32'(m_ins[7:3]));
      check("cyc_operand",     32'(bus.operand),     32'(m_ins[2:0]));
      check("cyc_issue_pc",    32'(bus.issue_pc),    32'(m_ipc));
      if (m_st == EXP_REQ) check("cyc_mem_addr", 32'(bus.mem_addr), 32'(m_pc));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[0] = 8'h0B;
    mem[1] = 8'h3A;

    rst_n           = 1'b0;
    bus.mem_ready   = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 8'h00;
    bus.halt        = 1'b0;
    repeat (3) tick();
    chk_en = 1'b1;

    // Reset state
    check("rst_mem_req",     32'(bus.mem_req),     32'd0);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_halted",      32'(bus.halted),      32'd0);
    check("rst_opcode",      32'(bus.opcode),      32'd0);
    check("rst_operand",     32'(bus.operand),     32'd0);
    check("rst_issue_pc",    32'(bus.issue_pc),    32'd0);

    // Reset release, zero-wait memory, execute always ready
    rst_n = 1'b1;
    tick();
    check("t1_first_req",  32'(bus.mem_req),  32'd1);
    check("t1_first_addr", 32'(bus.mem_addr), 32'h00);
    tick();
    check("t1_i0_valid",   32'(bus.instr_valid), 32'd1);
    check("t1_i0_opcode",  32'(bus.opcode),      32'h01);
    check("t1_i0_operand", 32'(bus.operand),     32'h3);
    check("t1_i0_pc",      32'(bus.issue_pc),    32'h00);
    tick();
    check("t1_i0_gone",    32'(bus.instr_valid), 32'd0);
    check("t1_addr1",      32'(bus.mem_addr),    32'h01);
    tick();
    check("t1_i1_opcode",  32'(bus.opcode),      32'h07);
    check("t1_i1_operand", 32'(bus.operand),     32'h2);
    check("t1_i1_pc",      32'(bus.issue_pc),    32'h01);

    // Three memory wait cycles on the fetch of address 2
    bus.mem_ready = 1'b0;
    cnt = 0;
    tick();
    repeat (3) begin
      if (bus.mem_req && bus.mem_addr == 8'h02) cnt++;
      tick();
    end
    if (bus.mem_req && bus.mem_addr == 8'h02) cnt++;
    check("t2_req_held_cycles", 32'(cnt), 32'd4);
    check("t2_not_yet_valid", 32'(bus.instr_valid), 32'd0);
    bus.mem_ready = 1'b1;
    tick();
    check("t2_valid_after_ready", 32'(bus.instr_valid), 32'd1);
    check("t2_issue_pc",          32'(bus.issue_pc),    32'h02);

    // Backpressure with redirect/halt asserted but not accepted
    bus.instr_ready = 1'b0;
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 8'h77;
    bus.halt        = 1'b1;
    cnt = 0;
    repeat (5) begin
      tick();
      if (bus.instr_valid && !bus.mem_req && !bus.halted && bus.issue_pc == 8'h02 &&
          bus.opcode == 5'b11000 && bus.operand == 3'b001) cnt++;
    end
    check("t3_held_cycles", 32'(cnt), 32'd5);
    bus.redirect_en = 1'b0;
    bus.halt        = 1'b0;
    bus.instr_ready = 1'b1;
    tick();
    check("t3_next_req",  32'(bus.mem_req),  32'd1);
    check("t3_next_addr", 32'(bus.mem_addr), 32'h03);

    // Redirects: ignored on fetch edges and stalls, honoured on acceptance
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 8'h10;
    tick();
    check("t4_issue3_pc", 32'(bus.issue_pc), 32'h03);
    tick();
    check("t4_redir_addr10", 32'(bus.mem_addr), 32'h10);
    bus.redirect_pc = 8'h99;
    tick();
    check("t4_issue10_pc", 32'(bus.issue_pc), 32'h10);
    bus.instr_ready = 1'b0;
    tick();
    check("t4_stall_valid", 32'(bus.instr_valid), 32'd1);
    bus.instr_ready = 1'b1;
    bus.redirect_pc = 8'h40;
    tick();
    check("t4_redir_addr40", 32'(bus.mem_addr), 32'h40);
    bus.redirect_pc = 8'h99;
    tick();
    bus.redirect_en = 1'b0;
    tick();
    check("t4_seq_addr41", 32'(bus.mem_addr), 32'h41);

    // PC wrap at 8'hFF
    tick();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 8'hFF;
    tick();
    bus.redirect_en = 1'b0;
    check("t5_addr_ff", 32'(bus.mem_addr), 32'hFF);
    tick();
    check("t5_ff_opcode",  32'(bus.opcode),   32'h07);
    check("t5_ff_operand", 32'(bus.operand),  32'h4);
    check("t5_ff_pc",      32'(bus.issue_pc), 32'hFF);
    tick();
    check("t5_wrap_addr", 32'(bus.mem_addr), 32'h00);
    tick();

    // Halt together with a redirect on the accepting edge
    bus.halt        = 1'b1;
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 8'h20;
    tick();
    check("t5_halted",     32'(bus.halted),      32'd1);
    check("t5_halt_valid", 32'(bus.instr_valid), 32'd0);
    bus.halt        = 1'b0;
    bus.redirect_en = 1'b0;
    cnt = 0;
    repeat (20) begin
      tick();
      if (bus.mem_req || bus.instr_valid || !bus.halted) cnt++;
    end
    check("t5_parked_cycles_bad", 32'(cnt), 32'd0);
    rst_n = 1'b0;
    tick();
    check("t5_rst_halted", 32'(bus.halted), 32'd0);
    rst_n = 1'b1;
    tick();
    check("t5_refetch_req",  32'(bus.mem_req),  32'd1);
    check("t5_refetch_addr", 32'(bus.mem_addr), 32'h00);

    // Reset while a fetch completes on the same edge
    rst_n = 1'b0;
    tick();
    check("t6_valid",  32'(bus.instr_valid), 32'd0);
    check("t6_opcode", 32'(bus.opcode),      32'd0);
    check("t6_req",    32'(bus.mem_req),     32'd0);
    rst_n = 1'b1;
    tick();
    check("t6_req_after",  32'(bus.mem_req),     32'd1);
    check("t6_addr_after", 32'(bus.mem_addr),    32'h00);
    check("t6_no_late",    32'(bus.instr_valid), 32'd0);
    tick();
    check("t6_i0_opcode", 32'(bus.opcode),   32'h01);
    check("t6_i0_pc",     32'(bus.issue_pc), 32'h00);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch/issue front end of the WF8 8-bit core.
- Owns the program counter and fetches one 8-bit instruction per request over a valid/ready memory port.
- Latches the instruction and presents it as opcode[4:0] / operand[2:0] to the control decoder and datapath, holding it until execute accepts it.
- Takes the next-PC redirect from execute for jumps and branches.

Parameters:
- PC_W, 8, program counter / instruction address width.
- RESET_PC, 8'h00, first fetch address after reset (PC_W bits).

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset
- mem_req  output  1  instruction read request
- mem_addr  output  PC_W  instruction address; valid while mem_req=1
- mem_ready  input  1  read data valid this cycle; completes the request
- mem_rdata  input  8  instruction byte, sampled when mem_req&mem_ready
- instr_valid  output  1  opcode/operand/issue_pc hold a live instruction
- instr_ready  input  1  execute accepts the instruction this cycle
- opcode  output  5  instruction bits [7:3], to control decoder
- operand  output  3  instruction bits [2:0]: reg index x0..x6 or 3-bit immediate
- issue_pc  output  PC_W  address of the instruction currently issued (PC-relative ALU source)
- redirect_en  input  1  execute requests a PC change for the accepted instruction
- redirect_pc  input  PC_W  new fetch address
- halt  input  1  stop fetching after the accepted instruction
- halted  output  1  fetch unit parked in HALT

Behaviour:
- Reset is synchronous and active-low, on clk rising edge.
- While rst_n=0, on each edge:
  - state=RESET, pc=RESET_PC
  - mem_req=0, instr_valid=0, halted=0
  - opcode=0, operand=0, issue_pc=0
- Reset mid-fetch or mid-issue abandons the operation. A late mem_ready is ignored.
- States: RESET, FETCH, ISSUE, HALT. All outputs are registered or decoded from state only; no comb path from inputs to outputs.
- RESET -> FETCH on the first edge with rst_n=1.
- FETCH:
  - mem_req=1, mem_addr=pc. Address stays stable until mem_ready.
  - On an edge with mem_ready=1:
    - {opcode,operand} <= mem_rdata
    - issue_pc <= pc
    - pc <= pc+1, modulo 2^PC_W (8'hFF wraps to 8'h00)
    - state -> ISSUE
  - mem_ready=0: stay in FETCH, request held.
- ISSUE:
  - mem_req=0, instr_valid=1. opcode/operand/issue_pc are held stable.
  - On an edge with instr_ready=1:
    - redirect_en=1 -> pc <= redirect_pc; else pc unchanged (already issue_pc+1).
    - halt=1 -> HALT; else -> FETCH.
    - redirect_en and halt in the same cycle: pc is updated, then HALT.
  - instr_ready=0: stay; redirect_en and halt ignored.
- HALT:
  - halted=1, instr_valid=0, mem_req=0, pc frozen.
  - Exit only by reset.
- redirect_en and halt are honoured only on the accepting edge (ISSUE & instr_ready). They are ignored in all other states.
- Timing:
  - Minimum latency is 1 cycle FETCH + 1 cycle ISSUE, i.e. 2 cycles per instruction with zero-wait memory and instr_ready tied high.
  - First mem_req appears 1 cycle after rst_n rises.
- mem_rdata is never sampled outside FETCH&mem_ready.

Decomposition:
- Shared params.vh additions:
  - `INSTR_W 8, `OPCODE_W 5, `OPERAND_W 3
  - `IF_STATE_W 2, with encodings `IF_RESET=0, `IF_FETCH=1, `IF_ISSUE=2, `IF_HALT=3
- Single flat module; no sub-module warranted. The instruction register and PC are a few lines each.

Test Plan:
- Reset release, RESET_PC=0, memory {0:8'h0B, 1:8'h3A}, zero-wait, instr_ready=1:
  - mem_req=1 with addr 0 one cycle after rst_n rises.
  - opcode=5'b00001, operand=3'b011, issue_pc=0.
  - Then opcode=5'b00111, operand=3'b010, issue_pc=1.
  - Each instruction valid exactly 1 cycle, 2-cycle cadence.
- Memory wait 3 cycles:
  - mem_req and mem_addr held stable for 4 cycles.
  - instr_valid rises the cycle after mem_ready.
- Backpressure (instr_ready=0 for 5 cycles):
  - opcode/operand/issue_pc unchanged; no mem_req.
  - Fetch of pc+1 starts the cycle after acceptance.
- Redirect:
  - Accept at issue_pc=8'h10 with redirect_en=1, redirect_pc=8'h40 -> next mem_addr=8'h40.
  - redirect_en asserted while not accepting -> ignored, next addr 8'h11.
- Wrap and halt:
  - Fetch at 8'hFF -> next fetch addr 8'h00.
  - Accept with halt=1 -> halted=1, no further mem_req for 20 cycles.
  - rst_n low 1 cycle -> refetch from RESET_PC.
- Reset mid-FETCH:
  - rst_n=0 while mem_req=1, with mem_ready arriving the same cycle.
  - Result: instr_valid stays 0, opcode=0, pc=RESET_PC.
